// File: rtl/uart_tx_buffer_if.sv
// Handshake bundle between the system writer, the byte buffer and the UART transmitter.
// master = system/transmitter side, slave = the buffer itself.
interface uart_tx_buffer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [7:0]          tx_din;
    logic                tx_flag;
    logic                tx_done;
    logic [DEPTH_LOG2:0] level;
    logic                busy;

    modport master (
        output wr_data, wr_valid, tx_done,
        input  wr_ready, tx_din, tx_flag, level, busy
    );

    modport slave (
        input  wr_data, wr_valid, tx_done,
        output wr_ready, tx_din, tx_flag, level, busy
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter one byte per frame: pop, one-cycle launch
// pulse, then wait for the transmitter to go busy and return idle before the next pop.
module uart_tx_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_buffer_if.slave bus
);
    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_KICK      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [7:0]            r_tx_din;
    logic                  r_tx_flag;
    logic                  w_full;
    logic                  w_wr_ready;
    logic                  w_wr;
    logic                  w_pop;

    // Ready depends only on registered level, never on tx_done or wr_valid.
    assign w_full     = (r_level == LVL_FULL);
    assign w_wr_ready = ~rst & ~w_full;
    assign w_wr       = bus.wr_valid & w_wr_ready;

    // Launch sequencing: pop only when data is present and the transmitter reports idle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_level != LVL_ZERO) && bus.tx_done) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_KICK;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_KICK: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!bus.tx_done) begin
                    w_state_nxt = S_WAIT_DONE;
                end else begin
                    w_state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, pointers, level and the registered transmitter-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= PTR_ZERO;
            r_rd_ptr  <= PTR_ZERO;
            r_level   <= LVL_ZERO;
            r_tx_din  <= 8'h00;
            r_tx_flag <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_flag <= w_pop;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_tx_din <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.wr_ready = w_wr_ready;
    assign bus.tx_din   = r_tx_din;
    assign bus.tx_flag  = r_tx_flag;
    assign bus.level    = r_level;
    assign bus.busy     = (r_level != LVL_ZERO) | (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: byte-queue reference model, behavioural transmitter
// with configurable frame length, and directed phases with random payloads.
module tb_uart_tx_buffer;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    int         p0 = 0;
    int         frame_len = 4;
    logic       force_busy = 1'b0;
    logic [7:0] cap_byte = 8'h00;
    logic [7:0] sb_q[$];
    logic [7:0] t5_first;

    uart_tx_buffer_if #(.DEPTH_LOG2(4)) bus ();

    uart_tx_buffer #(.DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: accepted bytes queue up, each launch pulse takes the oldest one.
    initial begin : monitor
        logic       s_rst;
        logic       s_wr;
        logic [7:0] s_data;
        logic [7:0] exp_b;
        int         pre;
        forever begin
            @(posedge clk);
            s_rst  = rst;
            pre    = sb_q.size();
            s_wr   = bus.wr_valid && !rst && (pre < DEPTH);
            s_data = bus.wr_data;
            #1;
            if (s_rst) begin
                sb_q.delete();
                chk("rst_flag", 32'(bus.tx_flag), 32'd0);
            end else begin
                if (s_wr) sb_q.push_back(s_data);
                if (bus.tx_flag === 1'b1) begin
                    pulses++;
                    chk("pop_nonempty", 32'(pre != 0), 32'd1);
                    if (pre != 0) begin
                        exp_b = sb_q.pop_front();
                        chk("pop_data", 32'(bus.tx_din), 32'(exp_b));
                    end
                end
            end
            chk("level", 32'(bus.level), 32'(sb_q.size()));
            chk("wr_ready", 32'(bus.wr_ready), 32'(!rst && (sb_q.size() < DEPTH)));
        end
    end

    // Transmitter model: busy for frame_len cycles after each launch pulse.
    initial begin : txm
        int cnt;
        cnt = 0;
        bus.tx_done = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                bus.tx_done = 1'b1;
                cnt = 0;
            end else if (force_busy) begin
                bus.tx_done = 1'b0;
                cnt = 0;
            end else if (bus.tx_flag) begin
                chk("flag_when_idle", 32'(bus.tx_done), 32'd1);
                cap_byte    = bus.tx_din;
                bus.tx_done = 1'b0;
                cnt         = frame_len;
            end else if (!bus.tx_done) begin
                if (cnt == 0) begin
                    bus.tx_done = 1'b1;
                end else begin
                    chk("din_stable", 32'(bus.tx_din), 32'(cap_byte));
                    cnt--;
                    if (cnt == 0) bus.tx_done = 1'b1;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        while (!acc && n < 400) begin
            @(posedge clk);
            acc = bus.wr_ready;
            n++;
        end
        chk("push_accept", 32'(acc), 32'd1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!((bus.busy === 1'b0) && (bus.tx_done === 1'b1) && (sb_q.size() == 0)) && (n < budget));
        chk("drain", 32'(n < budget), 32'd1);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_din", 32'(bus.tx_din), 32'h00);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Single byte: level 1 after E0, pulse with A5 after E0+1, pulse gone after E0+2.
        frame_len = 6;
        p0 = pulses;
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hA5;
        @(posedge clk); #1;
        chk("t1_level_e0", 32'(bus.level), 32'd1);
        chk("t1_flag_e0", 32'(bus.tx_flag), 32'd0);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        @(posedge clk); #1;
        chk("t1_flag_e1", 32'(bus.tx_flag), 32'd1);
        chk("t1_din_e1", 32'(bus.tx_din), 32'hA5);
        chk("t1_level_e1", 32'(bus.level), 32'd0);
        @(posedge clk); #1;
        chk("t1_flag_e2", 32'(bus.tx_flag), 32'd0);
        chk("t1_din_e2", 32'(bus.tx_din), 32'hA5);
        wait_drain(200);
        chk("t1_pulses", 32'(pulses - p0), 32'd1);

        // Fill to full while the transmitter is held busy; a 17th byte must stall.
        @(negedge clk);
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        @(posedge clk); #1;
        chk("t2_full_level", 32'(bus.level), 32'd16);
        chk("t2_full_ready", 32'(bus.wr_ready), 32'd0);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t2_stall_ready", 32'(bus.wr_ready), 32'd0);
            chk("t2_stall_level", 32'(bus.level), 32'd16);
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        p0 = pulses;
        frame_len = 3;
        force_busy = 1'b0;
        wait_drain(2000);
        chk("t2_pulses", 32'(pulses - p0), 32'd16);

        // Long frames, three random bytes.
        frame_len = 100;
        p0 = pulses;
        for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
        wait_drain(2000);
        chk("t3_pulses", 32'(pulses - p0), 32'd3);

        // Writes overlapping the drain, 20 bytes so both pointers wrap.
        frame_len = int'($urandom_range(2, 5));
        p0 = pulses;
        for (int i = 0; i < 20; i++) push(8'($urandom));
        wait_drain(3000);
        chk("t4_pulses", 32'(pulses - p0), 32'd20);

        // Write and pop on the same edge at level 1.
        @(negedge clk);
        force_busy = 1'b1;
        t5_first = 8'($urandom);
        p0 = pulses;
        push(t5_first);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = ~t5_first;
        force_busy   = 1'b0;
        @(posedge clk); #1;
        chk("t5_level", 32'(bus.level), 32'd1);
        chk("t5_flag", 32'(bus.tx_flag), 32'd1);
        chk("t5_din", 32'(bus.tx_din), 32'(t5_first));
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_drain(500);
        chk("t5_pulses", 32'(pulses - p0), 32'd2);

        // Reset while waiting on a frame with five bytes still queued.
        frame_len = 50;
        for (int i = 0; i < 6; i++) push(8'($urandom));
        @(posedge clk); #1;
        chk("t6_pre_level", 32'(bus.level), 32'd5);
        chk("t6_pre_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_level", 32'(bus.level), 32'd0);
        chk("t6_rst_flag", 32'(bus.tx_flag), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        p0 = pulses;
        repeat (100) @(posedge clk);
        #2;
        chk("t6_no_pulses", 32'(pulses - p0), 32'd0);
        chk("t6_idle_busy", 32'(bus.busy), 32'd0);
        frame_len = 4;
        push(8'h3C);
        wait_drain(500);
        chk("t6_restart_pulses", 32'(pulses - p0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Byte FIFO and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the system side on a valid/ready interface and buffers them. It then feeds the transmitter one byte at a time through its parallel data input, one-cycle start-flag and done-status handshake. The goal is back-to-back serial output with no byte lost or duplicated.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 2..8

Ports:
clk  input  1  system clock, same clock as the transmitter
rst  input  1  synchronous, active-high reset; top level drives the transmitter's active-low reset with its inverse
wr_data  input  8  byte to enqueue
wr_valid  input  1  wr_data is valid this cycle
wr_ready  output  1  FIFO can accept; a write occurs on a rising edge where wr_valid & wr_ready
tx_din  output  8  byte presented to the transmitter data input
tx_flag  output  1  one-cycle launch pulse to the transmitter
tx_done  input  1  transmitter status: 1 = idle, 0 = sending
level  output  DEPTH_LOG2+1  number of bytes stored, 0..2^DEPTH_LOG2
busy  output  1  level != 0 or FSM not in S_IDLE

Behaviour:
- Reset (rst=1 at a rising edge): level=0, read/write pointers=0, FSM=S_IDLE, tx_flag=0, tx_din=8'h00. wr_ready=0 while rst is high. Memory contents are don't-care.
- Reset mid-transfer: FIFO contents are discarded, tx_flag drops at once, FSM returns to S_IDLE. The transmitter is reset by the same reset, so no partial-frame recovery is required.
- wr_ready = ~rst & (level != 2^DEPTH_LOG2). It is derived from registered level only, with no combinational path from tx_done or wr_valid.
- Write accepted: mem[wr_ptr] <= wr_data, and wr_ptr increments modulo depth (natural wrap).
- Pop (FSM leaving S_IDLE): tx_din <= mem[rd_ptr], and rd_ptr increments modulo depth.
- level update per edge: +1 on write only, -1 on pop only, unchanged on write and pop together.
- Write while full is impossible, because wr_ready=0. Pop while empty is impossible, because of the FSM guard. level must never exceed depth or underflow.
- tx_din is registered and held stable from the pop edge until the next pop. The transmitter captures it some cycles after tx_flag.
- FSM states:
  - S_IDLE: if level!=0 and tx_done=1 -> pop, set tx_flag<=1, go to S_KICK. Otherwise stay.
  - S_KICK: tx_flag is high for exactly this one cycle, then tx_flag<=0 and go to S_WAIT_BUSY.
  - S_WAIT_BUSY: wait for tx_done=0, then go to S_WAIT_DONE. tx_flag stays 0. No timeout. If the transmitter already dropped done, the state lasts 1 cycle.
  - S_WAIT_DONE: wait for tx_done=1, then go to S_IDLE.
- Latency: a write into an empty FIFO, with the transmitter idle, at edge E0 sets level=1 after E0. The pop occurs at E0+1, so tx_flag and the new tx_din are visible after E0+1. tx_flag falls at E0+2.
- Back-to-back: the next pop occurs on the first edge where the FSM is in S_IDLE and tx_done=1. That is at least 1 cycle after tx_done returns high, so there are no stray pulses while the transmitter is busy.
- tx_flag is never high in any state other than S_KICK. Exactly one pulse is issued per popped byte.
- A write and a pop in the same cycle at level=1 leaves level=1 and data order is preserved.

Test Plan:
- Reset, then a single write of 8'hA5 with tx_done=1 -> level 0->1->0; tx_din=8'hA5 with tx_flag high for exactly 1 cycle, 2 edges after the write.
- Burst of 16 writes (8'h00..8'h0F) while a transmitter model holds tx_done=0 -> wr_ready=0 at level=16; a 17th write is stalled and not stored; after draining, bytes emerge in order 00..0F.
- Transmitter model with 100-cycle frames and 3 bytes queued -> exactly 3 tx_flag pulses, each only after tx_done has returned high; tx_din is stable across each frame.
- Writes continuing during a drain across a pointer wrap (push 20 bytes total at depth 16) -> output sequence equals input sequence; level matches a scoreboard every cycle.
- Simultaneous write and pop at level=1 -> level stays 1, with no loss and no duplication.
- Assert rst for 1 cycle during S_WAIT_DONE with level=5 -> the next cycle shows level=0, tx_flag=0, busy=0, and no further pulses until new writes arrive.
